dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages (latency in enabled cycles); legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge only.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  clock enable; 1 = advance pipeline, 0 = hold (stall).
REQ-007 flush  input  1  invalidate all stages (present only with DFF_PIPE_FLUSH_EN).
REQ-008 d  input  WIDTH  data into stage 0.
REQ-009 d_valid  input  1  qualifies d.
REQ-010 out  output  WIDTH  data of last stage (DEPTH-1), registered.
REQ-011 out_valid  output  1  valid bit of last stage, registered.
REQ-012 occ  output  $clog2(DEPTH+1)  count of stages holding valid data, registered.

Function
REQ-013 Each stage i SHALL hold a data register data[i] and a valid bit vld[i].
REQ-014 On a rising edge with en=1: data[0]<=d, vld[0]<=d_valid, and data[i]<=data[i-1], vld[i]<=vld[i-1] for 1<=i<DEPTH.
REQ-015 On a rising edge with en=0: all data[], vld[], and occ SHALL hold.
REQ-016 Data SHALL shift regardless of valid; invalid stages carry data but out is meaningful only when out_valid=1.
REQ-017 Latency: d sampled on edge k SHALL appear on out after exactly DEPTH enabled edges; disabled edges add no delay count.
REQ-018 out = data[DEPTH-1] and out_valid = vld[DEPTH-1]; no combinational path from any input to any output.
REQ-019 occ SHALL be a counter updated per enabled edge as occ + d_valid - vld[DEPTH-1], never exceeding DEPTH nor below 0.
REQ-020 Full pipeline (occ=DEPTH) with en=1 and d_valid=1 SHALL keep occ=DEPTH (one enters, one leaves); there is no back-pressure.
REQ-021 DEPTH=1 SHALL behave as a single enabled D flip-flop with valid, latency 1.

Reset
REQ-022 rst=1 at a rising edge SHALL set all data[] to RESET_VAL, all vld[] to 0, occ to 0, regardless of en, flush, d_valid.
REQ-023 After reset: out=RESET_VAL, out_valid=0, occ=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight data; the first post-reset enabled edge loads only stage 0.
REQ-025 rst has priority over flush, which has priority over en.

Configuration
REQ-026 Macro DFF_PIPE_FLUSH_EN defined: flush port exists; flush=1 at a rising edge SHALL clear all vld[] and occ to 0, leave data[] unchanged, and not capture d_valid, independent of en.
REQ-027 Macro undefined: flush port SHALL be absent and flush logic not synthesised; all other behaviour identical.

Structure
REQ-028 A shared package dff_pipe_pkg SHALL hold the WIDTH/DEPTH limit constants and the occupancy-width function (clog2 of DEPTH+1).
REQ-029 One sub-module dff_en (single WIDTH-bit register with synchronous reset and enable) SHALL be instantiated per stage; valid bits and occ live in dff_pipe.

Verification
REQ-030 Reset: rst=1 for 2 edges with d=8'hFF, d_valid=1, en=1 -> out=8'h00, out_valid=0, occ=0.
REQ-031 Latency: DEPTH=4, en=1, d=8'hA5 d_valid=1 for one edge then d_valid=0 -> out=8'hA5, out_valid=1 exactly 4 edges later for one cycle; occ goes 1,1,1,1,0.
REQ-032 Stall: same stimulus with en=0 for 3 edges after edge 2 -> out_valid=1 on edge 7, occ holds 1 during stall.
REQ-033 Full streaming: d_valid=1, d=1,2,3,... every edge, en=1 -> occ reaches 4 after edge 4 and stays 4; out sequence 1,2,3,... starting edge 4.
REQ-034 Flush (DFF_PIPE_FLUSH_EN): pipeline with occ=3, flush=1 with en=1, d_valid=1 -> next cycle occ=0, out_valid=0; no valid output for next 4 edges if d_valid=0.
REQ-035 Mid-stream reset: occ=4, rst=1 one edge -> occ=0, out=RESET_VAL; d=8'h3C d_valid=1 next edge -> occ=1, out_valid=1 after 4 edges with out=8'h3C.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared limits and helpers for the dff_pipe register pipeline.
// Both the pipeline top and its per-stage register import this package.
package dff_pipe_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_en.sv
// dff_en: one WIDTH-bit register with synchronous active-high reset and clock enable.
// Instantiated once per data stage of dff_pipe.
module dff_en
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled register pipeline with per-stage valid bits and occupancy count.
// Define DFF_PIPE_FLUSH_EN to add the flush port, which drops all valid bits but keeps data.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    output logic [occ_width(DEPTH)-1:0]  occ
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_vld_shift;
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_adv;

    // A flush freezes the data stages so their contents survive unchanged.
`ifdef DFF_PIPE_FLUSH_EN
    assign w_adv = en & ~flush;
`else
    assign w_adv = en;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                dff_en #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk (clk),
                    .rst (rst),
                    .en  (w_adv),
                    .d   (d),
                    .q   (w_data[gi])
                );
            end else begin : g_rest
                dff_en #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk (clk),
                    .rst (rst),
                    .en  (w_adv),
                    .d   (w_data[gi-1]),
                    .q   (w_data[gi])
                );
            end
        end

        if (DEPTH == 1) begin : g_vld_one
            assign w_vld_shift = d_valid;
        end else begin : g_vld_many
            assign w_vld_shift = {r_vld[DEPTH-2:0], d_valid};
        end
    endgenerate

    // Counter stays in 0..DEPTH because it tracks exactly the ones in r_vld.
    assign w_occ_next = r_occ + OCC_W'(d_valid) - OCC_W'(r_vld[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_occ <= '0;
        end
`ifdef DFF_PIPE_FLUSH_EN
        else if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
        end
`endif
        else if (en) begin
            r_vld <= w_vld_shift;
            r_occ <= w_occ_next;
        end
    end

    assign out       = w_data[DEPTH-1];
    assign out_valid = r_vld[DEPTH-1];
    assign occ       = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: directed scenarios then random traffic against a history-list model.
// Flush is exercised only when DFF_PIPE_FLUSH_EN is defined.
module tb_dff_pipe;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] RV = 8'h00;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         flush_s = 1'b0;
    logic [W-1:0] d = '0;
    logic         d_valid = 1'b0;
    logic [W-1:0] out;
    logic         out_valid;
    logic [2:0]   occ;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(W), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef DFF_PIPE_FLUSH_EN
        .flush     (flush_s),
`endif
        .d         (d),
        .d_valid   (d_valid),
        .out       (out),
        .out_valid (out_valid),
        .occ       (occ)
    );

    typedef struct {
        logic [W-1:0] out;
        bit           ov;
        int           occ;
    } exp_t;

    exp_t         sb[$];
    // Model: inputs of enabled edges since reset, newest first, at most DEPTH kept.
    logic [W-1:0] hist_d[$];
    bit           hist_v[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           edge_no  = 0;

    task automatic step(input bit r, input bit e, input bit f, input logic [W-1:0] dd, input bit v);
        exp_t x;
        int   cnt;
        rst = r; en = e; flush_s = f; d = dd; d_valid = v;
        @(posedge clk);
        #1;
        edge_no++;
        if (r) begin
            hist_d.delete();
            hist_v.delete();
        end else if (f) begin
            foreach (hist_v[k]) hist_v[k] = 1'b0;
        end else if (e) begin
            hist_d.push_front(dd);
            hist_v.push_front(v);
            if (hist_d.size() > DEPTH) begin
                void'(hist_d.pop_back());
                void'(hist_v.pop_back());
            end
        end
        cnt = 0;
        foreach (hist_v[k]) cnt += int'(hist_v[k]);
        x.out = (hist_d.size() == DEPTH) ? hist_d[DEPTH-1] : RV;
        x.ov  = (hist_v.size() == DEPTH) ? hist_v[DEPTH-1] : 1'b0;
        x.occ = cnt;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_no, act, req);
    endtask

    // Monitor: every cycle the DUT presents out/out_valid/occ; compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("out_valid", int'(out_valid), int'(x.ov));
                check("occ", int'(occ), x.occ);
                check("out", int'(out), int'(x.out));
                $display("edge %0d: out=%02h ov=%0b occ=%0d (exp %02h %0b %0d)",
                         edge_no, out, out_valid, occ, x.out, x.ov, x.occ);
            end
        end
    end

    initial begin
        bit fl;
        // Reset for two edges with active-looking inputs.
        step(1, 1, 0, 8'hFF, 1);
        step(1, 1, 0, 8'hFF, 1);
        // Latency: one valid word, then bubbles.
        step(0, 1, 0, 8'hA5, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, W'($urandom), 0);
        // Stall for three edges after the second edge.
        step(1, 1, 0, 8'h00, 0);
        step(0, 1, 0, 8'hA5, 1);
        step(0, 1, 0, 8'h11, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, W'($urandom), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h22, 0);
        // Full streaming 1,2,3,...
        step(1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 10; i++) step(0, 1, 0, W'(i), 1);
        // Mid-stream reset then one fresh word.
        step(1, 1, 0, 8'h77, 1);
        step(0, 1, 0, 8'h3C, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, W'($urandom), 0);
`ifdef DFF_PIPE_FLUSH_EN
        // Flush with occ=3, then bubbles must produce no valid output.
        for (int i = 0; i < 3; i++) step(0, 1, 0, W'(8'h50 + i), 1);
        step(0, 1, 1, 8'hEE, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, W'($urandom), 0);
`endif
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            fl = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
            fl = ($urandom_range(0, 29) == 0);
`endif
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, fl,
                 W'($urandom), $urandom_range(0, 1) == 1);
        end
        rst = 1'b0; en = 1'b0; flush_s = 1'b0; d_valid = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
